// File: rtl/button_scheduler.sv
// Debounced multi-button event scheduler: per-channel press/hold-off FSMs feeding a round-robin offer/ack arbiter.
// Optional BTN_SCHED_OVERFLOW_EN: sticky per-channel flags for presses dropped while an event is still pending.
module button_scheduler #(
    parameter int N_BTN     = 4,
    parameter int HOLD_BITS = 26,
    parameter int DATA_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_BTN-1:0]         btn_n,
    input  logic [DATA_W-1:0]        sw,
    output logic                     req_valid,
    output logic [$clog2(N_BTN)-1:0] req_id,
    output logic [DATA_W-1:0]        req_data,
    input  logic                     ack,
    output logic [N_BTN-1:0]         pending,
    output logic [N_BTN-1:0]         overflow
);
    localparam int ID_W = $clog2(N_BTN);

    typedef enum logic {CH_ARMED, CH_HOLD} ch_state_t;
    typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_t;

    logic [N_BTN-1:0]     sync_1, sync_2;
    ch_state_t            ch_state    [N_BTN];
    ch_state_t            ch_state_nx [N_BTN];
    logic [HOLD_BITS-1:0] hold_cnt    [N_BTN];
    logic [HOLD_BITS-1:0] hold_cnt_nx [N_BTN];
    logic [N_BTN-1:0]     press;

    arb_state_t           arb_state, arb_state_nx;
    logic [ID_W-1:0]      last_grant, grant_id, cand;
    logic                 grant_found, do_grant;
    logic [N_BTN-1:0]     grant_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    // Hold-off counter stops once its top bit is set; re-arm also needs the button released.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            ch_state_nx[i] = ch_state[i];
            hold_cnt_nx[i] = hold_cnt[i];
            press[i]       = 1'b0;
            case (ch_state[i])
                CH_ARMED: begin
                    if (!sync_2[i]) begin
                        press[i]       = 1'b1;
                        ch_state_nx[i] = CH_HOLD;
                    end
                end
                CH_HOLD: begin
                    if (hold_cnt[i][HOLD_BITS-1]) begin
                        if (sync_2[i]) begin
                            ch_state_nx[i] = CH_ARMED;
                            hold_cnt_nx[i] = '0;
                        end
                    end else begin
                        hold_cnt_nx[i] = hold_cnt[i] + HOLD_BITS'(1);
                    end
                end
                default: ch_state_nx[i] = CH_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                ch_state[i] <= CH_ARMED;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                ch_state[i] <= ch_state_nx[i];
                hold_cnt[i] <= hold_cnt_nx[i];
            end
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            cand = ID_W'((int'(last_grant) + k) % N_BTN);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        arb_state_nx = arb_state;
        do_grant     = 1'b0;
        case (arb_state)
            ARB_IDLE: begin
                if (grant_found) begin
                    do_grant     = 1'b1;
                    arb_state_nx = ARB_OFFER;
                end
            end
            ARB_OFFER: if (ack) arb_state_nx = ARB_IDLE;
            default:   arb_state_nx = ARB_IDLE;
        endcase
    end

    assign grant_clr = do_grant ? (N_BTN'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arb_state  <= ARB_IDLE;
            last_grant <= ID_W'(N_BTN - 1);
            req_valid  <= 1'b0;
            req_id     <= '0;
            req_data   <= '0;
        end else begin
            arb_state <= arb_state_nx;
            if (do_grant) begin
                req_valid <= 1'b1;
                req_id    <= grant_id;
                req_data  <= sw;
            end else if (arb_state == ARB_OFFER && ack) begin
                req_valid  <= 1'b0;
                last_grant <= req_id;
            end
        end
    end

    // A new press outranks the grant clearing the same channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= press | (pending & ~grant_clr);
    end

`ifdef BTN_SCHED_OVERFLOW_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overflow <= '0;
        else          overflow <= overflow | (press & pending & ~grant_clr);
    end
`else
    assign overflow = '0;
`endif

endmodule

// File: tb/tb_button_scheduler.sv
// Self-checking bench for button_scheduler: directed scenarios plus random presses/acks
// compared every cycle against a cycle-level behavioural model.
module tb_button_scheduler;
    localparam int N_BTN     = 4;
    localparam int HOLD_BITS = 6;
    localparam int DATA_W    = 16;
    localparam int HOLD_MAX  = 1 << (HOLD_BITS - 1);
`ifdef BTN_SCHED_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [N_BTN-1:0]  btn_n = '1;
    logic [DATA_W-1:0] sw = '0;
    logic              ack = 1'b0;
    logic              req_valid;
    logic [1:0]        req_id;
    logic [DATA_W-1:0] req_data;
    logic [N_BTN-1:0]  pending;
    logic [N_BTN-1:0]  overflow;

    int errors = 0;
    int checks = 0;
    bit glitch = 1'b0;
    int delivered[$];

    // Behavioural model state
    bit [N_BTN-1:0]    m_s1, m_s2, m_pend, m_ovf;
    bit                m_armed [N_BTN];
    int                m_cnt   [N_BTN];
    bit                m_busy;
    int                m_last, m_id;
    logic [DATA_W-1:0] m_data;

    always #5 clk = ~clk;

    button_scheduler #(.N_BTN(N_BTN), .HOLD_BITS(HOLD_BITS), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .btn_n(btn_n), .sw(sw),
        .req_valid(req_valid), .req_id(req_id), .req_data(req_data),
        .ack(ack), .pending(pending), .overflow(overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_pend = '0; m_ovf = '0;
        m_busy = 1'b0; m_last = N_BTN - 1; m_id = 0; m_data = '0;
        for (int i = 0; i < N_BTN; i++) begin
            m_armed[i] = 1'b1;
            m_cnt[i]   = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit [N_BTN-1:0] prs;
        bit [N_BTN-1:0] clr;
        int c;
        prs = '0; clr = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (m_armed[i]) begin
                if (!m_s2[i]) begin prs[i] = 1'b1; m_armed[i] = 1'b0; m_cnt[i] = 0; end
            end else if (m_cnt[i] >= HOLD_MAX) begin
                if (m_s2[i]) begin m_armed[i] = 1'b1; m_cnt[i] = 0; end
            end else begin
                m_cnt[i]++;
            end
        end
        if (!m_busy) begin
            for (int k = 1; k <= N_BTN; k++) begin
                c = (m_last + k) % N_BTN;
                if (m_pend[c]) begin
                    m_busy = 1'b1; m_id = c; m_data = sw; clr[c] = 1'b1;
                    break;
                end
            end
        end else if (ack) begin
            m_busy = 1'b0; m_last = m_id;
        end
        for (int i = 0; i < N_BTN; i++)
            if (prs[i] && m_pend[i] && !clr[i] && OVF_EN) m_ovf[i] = 1'b1;
        m_pend = prs | (m_pend & ~clr);
        m_s2 = m_s1;
        m_s1 = btn_n;
    endtask

    task automatic step();
        if (req_valid === 1'b1 && ack) delivered.push_back(int'(req_id));
        model_step();
        if (glitch) begin
            #1 btn_n[0] = 1'b0;
            #2 btn_n[0] = 1'b1;
            glitch = 1'b0;
        end
        @(negedge clk);
        check_val("req_valid", {31'b0, req_valid}, {31'b0, m_busy});
        check_val("pending", {28'b0, pending}, {28'b0, m_pend});
        check_val("overflow", {28'b0, overflow}, {28'b0, m_ovf});
        if (m_busy) begin
            check_val("req_id", {30'b0, req_id}, m_id);
            check_val("req_data", {16'b0, req_data}, {16'b0, m_data});
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    function automatic int count_id(input int id);
        int n = 0;
        foreach (delivered[j]) if (delivered[j] == id) n++;
        return n;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int tmr [N_BTN];
        bit prev_v;

        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_valid", {31'b0, req_valid}, 0);
        check_val("rst_id", {30'b0, req_id}, 0);
        check_val("rst_data", {16'b0, req_data}, 0);
        check_val("rst_pending", {28'b0, pending}, 0);
        check_val("rst_overflow", {28'b0, overflow}, 0);
        reset_n = 1'b1;

        // Three simultaneous presses, each offer acked one cycle late
        delivered.delete();
        btn_n = 4'b0100;
        prev_v = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) btn_n = '1;
            ack    = req_valid && prev_v;
            prev_v = req_valid && !ack;
            step();
        end
        ack = 1'b0;
        check_val("rr_count", delivered.size(), 3);
        check_val("rr_first", delivered.size() > 0 ? delivered[0] : -1, 0);
        check_val("rr_second", delivered.size() > 1 ? delivered[1] : -1, 1);
        check_val("rr_third", delivered.size() > 2 ? delivered[2] : -1, 3);
        ack = 1'b1;
        run(50);

        // Single press on ch2: latency and captured data
        ack = 1'b0;
        btn_n = 4'b1011;
        sw = 16'hA5A5;
        run(2);
        check_val("lat_pend_e1", {28'b0, pending}, 0);
        step();
        check_val("lat_pend_e2", {28'b0, pending}, 4'b0100);
        check_val("lat_valid_e2", {31'b0, req_valid}, 0);
        step();
        check_val("lat_valid_e3", {31'b0, req_valid}, 1);
        check_val("lat_id", {30'b0, req_id}, 2);
        check_val("lat_data", {16'b0, req_data}, 16'hA5A5);
        check_val("lat_pend_grant", {28'b0, pending}, 0);
        ack = 1'b1;
        sw = 16'h1234;
        step();
        check_val("lat_valid_ack", {31'b0, req_valid}, 0);
        btn_n = '1;
        run(50);

        // Long hold on ch1 yields exactly one event per press
        delivered.delete();
        btn_n = 4'b1101;
        run(100);
        btn_n = '1;
        run(40);
        btn_n = 4'b1101;
        run(10);
        btn_n = '1;
        run(50);
        check_val("hold_ch1_events", count_id(1), 2);

        // Re-press on ch0 while its first event is still pending behind a ch1 offer
        delivered.delete();
        ack = 1'b0;
        btn_n = 4'b1101;
        run(6);
        btn_n = 4'b1110;
        run(10);
        btn_n = '1;
        run(45);
        btn_n = 4'b1110;
        run(10);
        btn_n = '1;
        check_val("ovf_ch0", {31'b0, overflow[0]}, {31'b0, OVF_EN});
        ack = 1'b1;
        run(60);
        check_val("ovf_ch0_events", count_id(0), 1);

        // Sub-cycle glitches are never sampled
        for (int g = 0; g < 3; g++) begin
            glitch = 1'b1;
            run(6);
            check_val("glitch_pending", {28'b0, pending}, 0);
            check_val("glitch_valid", {31'b0, req_valid}, 0);
        end

        // Async reset mid-offer with other events pending
        ack = 1'b0;
        btn_n = 4'b1110;
        run(5);
        btn_n = 4'b0101;
        run(4);
        check_val("mid_pending", {28'b0, pending}, 4'b1010);
        check_val("mid_valid", {31'b0, req_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_valid", {31'b0, req_valid}, 0);
        check_val("arst_pending", {28'b0, pending}, 0);
        check_val("arst_overflow", {28'b0, overflow}, 0);
        check_val("arst_id", {30'b0, req_id}, 0);
        check_val("arst_data", {16'b0, req_data}, 0);
        model_reset();
        @(negedge clk);
        btn_n = '1;
        reset_n = 1'b1;
        delivered.delete();
        ack = 1'b1;
        btn_n = 4'b0111;
        run(2);
        btn_n = 4'b0110;
        run(15);
        btn_n = '1;
        run(50);
        check_val("post_rst_count", delivered.size(), 2);
        check_val("post_rst_first", delivered.size() > 0 ? delivered[0] : -1, 3);
        check_val("post_rst_second", delivered.size() > 1 ? delivered[1] : -1, 0);

        // Random presses, hold times, switch words and acks
        for (int i = 0; i < N_BTN; i++) tmr[i] = $urandom_range(1, 80);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_BTN; i++) begin
                tmr[i]--;
                if (tmr[i] <= 0) begin
                    btn_n[i] = ~btn_n[i];
                    tmr[i] = $urandom_range(1, 80);
                end
            end
            sw  = DATA_W'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
